// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-M stream demux: hold-stage state, packet lock mode, one-hot channel mask.
package demux_pkg;

  typedef enum logic {EMPTY, FULL} state_t;

  typedef enum logic [1:0] {UNLOCKED, LOCKED, DROP} lock_t;

  // Mask is 16 wide (largest supported M); callers size-cast it to M bits.
  function automatic logic [15:0] onehot(input logic [3:0] sel, input int m);
    logic [15:0] r;
    r = '0;
    if (int'(sel) < m) r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/demux_hold_reg.sv
// One-deep data+last holding register with load and clear; 1-cycle load latency, no flow control of its own.
module demux_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d_data,
  input  logic         d_last,
  output logic [W-1:0] q_data,
  output logic         q_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data <= '0;
      q_last <= 1'b0;
    end else if (load) begin
      q_data <= d_data;
      q_last <= d_last;
    end else if (clear) begin
      q_data <= '0;
      q_last <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1xm_stream.sv
// 1-to-M packet-locked stream demux, 1-cycle latency, full throughput; i_ready follows the selected y_ready.
// DEMUX_TRISTATE_EN: idle y_data slices drive 'z instead of 0.
module demux_1xm_stream
  import demux_pkg::*;
#(
  parameter int  W  = 8,
  parameter int  M  = 4,
  localparam int SW = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   i_data,
  input  logic           i_valid,
  input  logic           i_last,
  output logic           i_ready,
  input  logic [SW-1:0]  s,
  output logic [M*W-1:0] y_data,
  output logic [M-1:0]   y_valid,
  input  logic [M-1:0]   y_ready,
  output logic           y_last,
  output logic           busy,
  output logic           err
);

`ifdef DEMUX_TRISTATE_EN
  localparam logic [W-1:0] IDLE_SLICE = {W{1'bz}};
`else
  localparam logic [W-1:0] IDLE_SLICE = '0;
`endif

  state_t        state_q, state_d;
  lock_t         lock_q, lock_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          err_q;
  logic          full, first, oor, accept, drop_beat, load, xfer;
  logic [W-1:0]  data_q;
  logic          last_q;

  assign full    = (state_q == FULL);
  assign first   = (lock_q == UNLOCKED);
  assign oor     = first && (32'(s) >= 32'(M));
  assign i_ready = (lock_q == DROP) || !full || y_ready[ch_q];
  assign accept  = i_valid && i_ready;
  // Dropped beats never touch the hold stage or the channel latch.
  assign drop_beat = accept && ((lock_q == DROP) || oor);
  assign load      = accept && !drop_beat;
  assign xfer      = full && y_ready[ch_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      lock_q  <= UNLOCKED;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ch_q    <= ch_d;
      err_q   <= drop_beat;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ch_d    = ch_q;
    if (load) begin
      state_d = FULL;
      ch_d    = first ? s : ch_q;
    end else if (xfer) begin
      state_d = EMPTY;
    end
    if (accept) begin
      if (i_last)     lock_d = UNLOCKED;
      else if (first) lock_d = oor ? DROP : LOCKED;
    end
  end

  demux_hold_reg #(.W(W)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .clear  (xfer && !load),
    .d_data (i_data),
    .d_last (i_last),
    .q_data (data_q),
    .q_last (last_q)
  );

  assign y_valid = full ? M'(onehot(4'(ch_q), M)) : '0;
  assign y_last  = full && last_q;
  assign busy    = (lock_q != UNLOCKED);
  assign err     = err_q;

  for (genvar k = 0; k < M; k++) begin : g_slice
    assign y_data[k*W +: W] = (full && (ch_q == SW'(k))) ? data_q : IDLE_SLICE;
  end

endmodule

// File: tb/tb_demux_1xm_stream.sv
// Bench for demux_1xm_stream: an M=4 and an M=3 instance share stimulus and are checked against a packet-level model.
module tb_demux_1xm_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_valid, i_last;
  logic [1:0]  s;
  logic [3:0]  y_ready;
  logic        run;

  logic        rdy4, last4, busy4, err4;
  logic [31:0] dat4;
  logic [3:0]  vld4;
  logic        rdy3, last3, busy3, err3;
  logic [23:0] dat3;
  logic [2:0]  vld3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_1xm_stream #(.W(8), .M(4)) dut4 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .i_ready(rdy4), .s(s), .y_data(dat4), .y_valid(vld4), .y_ready(y_ready),
    .y_last(last4), .busy(busy4), .err(err4)
  );

  demux_1xm_stream #(.W(8), .M(3)) dut3 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .i_ready(rdy3), .s(s), .y_data(dat3), .y_valid(vld3), .y_ready(y_ready[2:0]),
    .y_last(last3), .busy(busy3), .err(err3)
  );

  // Packet-level model: index 0 is the M=4 instance, index 1 the M=3 instance.
  logic       mfull [2];
  logic [1:0] mch   [2];
  logic [7:0] mdata [2];
  logic       mlast [2];
  logic       minpkt[2];
  logic       mdrop [2];
  logic       merr  [2];

  function automatic logic e_rdy(input int n);
    return mdrop[n] || !mfull[n] || y_ready[mch[n]];
  endfunction

  function automatic logic [3:0] e_vld(input int n);
    return mfull[n] ? (4'b0001 << mch[n]) : 4'b0000;
  endfunction

  function automatic logic [31:0] e_dat(input int n);
    return mfull[n] ? (32'(mdata[n]) << (8 * mch[n])) : 32'h0;
  endfunction

  task automatic model_step(input int n);
    int   mm;
    logic acc, outgo, dropped;
    mm      = (n == 0) ? 4 : 3;
    acc     = i_valid && e_rdy(n);
    outgo   = mfull[n] && y_ready[mch[n]];
    dropped = acc && (mdrop[n] || (!minpkt[n] && int'(s) >= mm));
    merr[n] = dropped;
    if (outgo) mfull[n] = 1'b0;
    if (acc && !dropped) begin
      mfull[n] = 1'b1;
      if (!minpkt[n]) mch[n] = s;
      mdata[n] = i_data;
      mlast[n] = i_last;
    end
    if (acc) begin
      if (i_last) begin
        minpkt[n] = 1'b0;
        mdrop[n]  = 1'b0;
      end else if (!minpkt[n]) begin
        minpkt[n] = 1'b1;
        mdrop[n]  = dropped;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        mfull[n] = 1'b0; mch[n] = 2'd0; mdata[n] = 8'h0; mlast[n] = 1'b0;
        minpkt[n] = 1'b0; mdrop[n] = 1'b0; merr[n] = 1'b0;
      end
    end else begin
      for (int n = 0; n < 2; n++) model_step(n);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("m4 i_ready", 64'(rdy4), 64'(e_rdy(0)));
      chk("m4 y_valid", 64'(vld4), 64'(e_vld(0)));
      chk("m4 y_data",  64'(dat4), 64'(e_dat(0)));
      chk("m4 y_last",  64'(last4), 64'(mfull[0] && mlast[0]));
      chk("m4 busy",    64'(busy4), 64'(minpkt[0]));
      chk("m4 err",     64'(err4), 64'(merr[0]));
      chk("m3 i_ready", 64'(rdy3), 64'(e_rdy(1)));
      chk("m3 y_valid", 64'(vld3), 64'(e_vld(1)));
      chk("m3 y_data",  64'(dat3), 64'(e_dat(1)));
      chk("m3 y_last",  64'(last3), 64'(mfull[1] && mlast[1]));
      chk("m3 busy",    64'(busy3), 64'(minpkt[1]));
      chk("m3 err",     64'(err3), 64'(merr[1]));
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic [1:0] sel);
    i_valid = v; i_data = d; i_last = l; s = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    run = 1'b0;
    rst = 1'b1;
    y_ready = 4'hF;
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    #12;
    chk("reset y_valid", 64'(vld4), 64'h0);
    chk("reset y_data",  64'(dat4), 64'h0);
    chk("reset y_last",  64'(last4), 64'h0);
    chk("reset busy",    64'(busy4), 64'h0);
    chk("reset err",     64'(err4), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    #1;
    chk("post-reset i_ready", 64'(rdy4), 64'h1);

    // Single-beat routing to channel 2
    tick();
    drive(1'b1, 8'hA5, 1'b1, 2'd2);
    tick();
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    @(negedge clk);
    chk("single y_valid", 64'(vld4), 64'h4);
    chk("single y_data",  64'(dat4), 64'h00A50000);
    chk("single busy",    64'(busy4), 64'h0);

    // Three-beat packet locked to channel 1 while s wanders
    tick();
    drive(1'b1, 8'h11, 1'b0, 2'd1);
    tick();
    drive(1'b1, 8'h22, 1'b0, 2'd3);
    @(negedge clk);
    chk("lock b1 y_valid", 64'(vld4), 64'h2);
    chk("lock b1 y_data",  64'(dat4), 64'h00001100);
    chk("lock b1 busy",    64'(busy4), 64'h1);
    tick();
    drive(1'b1, 8'h33, 1'b1, 2'd0);
    @(negedge clk);
    chk("lock b2 y_data",  64'(dat4), 64'h00002200);
    tick();
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    @(negedge clk);
    chk("lock b3 y_data",  64'(dat4), 64'h00003300);
    chk("lock b3 y_last",  64'(last4), 64'h1);
    chk("lock b3 busy",    64'(busy4), 64'h0);

    // Channel 0 stalled; a ready channel 3 must not release it
    tick();
    y_ready = 4'b1000;
    drive(1'b1, 8'h44, 1'b1, 2'd0);
    tick();
    drive(1'b1, 8'h55, 1'b1, 2'd0);
    repeat (4) begin
      @(negedge clk);
      chk("stall i_ready", 64'(rdy4), 64'h0);
      chk("stall y_data",  64'(dat4), 64'h00000044);
      chk("stall y_valid", 64'(vld4), 64'h1);
      tick();
    end
    y_ready = 4'hF;
    tick();
    drive(1'b1, 8'h66, 1'b1, 2'd0);
    @(negedge clk);
    chk("release beat 1", 64'(dat4), 64'h00000055);
    tick();
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    @(negedge clk);
    chk("release beat 2", 64'(dat4), 64'h00000066);

    // Out-of-range select on the M=3 instance
    tick();
    drive(1'b1, 8'hAA, 1'b0, 2'd3);
    tick();
    drive(1'b1, 8'hBB, 1'b1, 2'd2);
    @(negedge clk);
    chk("oor b1 err",     64'(err3), 64'h1);
    chk("oor b1 y_valid", 64'(vld3), 64'h0);
    chk("oor b1 busy",    64'(busy3), 64'h1);
    chk("oor b1 i_ready", 64'(rdy3), 64'h1);
    tick();
    drive(1'b1, 8'hCC, 1'b1, 2'd1);
    @(negedge clk);
    chk("oor b2 err",     64'(err3), 64'h1);
    chk("oor b2 y_valid", 64'(vld3), 64'h0);
    chk("oor b2 busy",    64'(busy3), 64'h0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    @(negedge clk);
    chk("oor next y_valid", 64'(vld3), 64'h2);
    chk("oor next y_data",  64'(dat3), 64'h00CC00);
    chk("oor next err",     64'(err3), 64'h0);

    // Asynchronous reset in the middle of a packet
    tick();
    drive(1'b1, 8'h77, 1'b0, 2'd2);
    tick();
    drive(1'b1, 8'h78, 1'b0, 2'd2);
    tick();
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid-rst y_valid", 64'(vld4), 64'h0);
    chk("mid-rst busy",    64'(busy4), 64'h0);
    rst = 1'b0;
    tick();
    drive(1'b1, 8'h79, 1'b1, 2'd0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    @(negedge clk);
    chk("after-rst y_valid", 64'(vld4), 64'h1);
    chk("after-rst y_data",  64'(dat4), 64'h00000079);

    // Random traffic checked every cycle by the compare process
    tick();
    repeat (3000) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
            2'($urandom_range(0, 3)));
      y_ready = 4'($urandom) | 4'($urandom);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 2'd0);
    y_ready = 4'hF;
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1xm_stream.md
Name: demux_1xm_stream

Overview:
- Parametrised 1-to-M stream demultiplexer. Successor to the 2-way combinational demux.
- Routes a W-bit input stream to one of M output channels through a one-deep registered stage with valid/ready handshakes.
- Locks the channel for the length of a packet.
- Sits between a single producer and M consumer ports in datapath routing.

Parameters:
- W, 8, data width per channel.
- M, 4, number of output channels (2..16).
- SW, $clog2(M), select width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_data  input  W  input beat data.
- i_valid  input  1  input beat valid.
- i_last  input  1  marks the final beat of a packet.
- i_ready  output  1  block can accept a beat this cycle.
- s  input  SW  channel select; sampled only on the first beat of a packet.
- y_data  output  M*W  channel k occupies bits [k*W +: W].
- y_valid  output  M  per-channel valid; at most one bit high (one-hot).
- y_ready  input  M  per-channel ready.
- y_last  output  1  last flag of the held beat.
- busy  output  1  high while a packet is in progress (lock set).
- err  output  1  one-cycle pulse when a beat is dropped for an out-of-range select.

Behaviour:
- Reset (async, rst=1): hold register empty; y_valid=0; y_data=0; y_last=0; lock=0; ch_q=0; err=0; busy=0. i_ready=1 once rst deasserts.
- Hold stage states:
  - EMPTY: y_valid=0.
  - FULL: y_valid[ch_q]=1, y_data[ch_q slice]=data_q, y_last=last_q.
- i_ready = EMPTY | y_ready[ch_q]. This gives full throughput: output and accept can happen in the same cycle.
- Accept: i_valid & i_ready.
  - Channel used = lock ? ch_q : s.
  - Captures i_data and i_last.
  - Registered in the next cycle; latency is 1 cycle from accept to y_valid.
- Output transfer: FULL & y_ready[ch_q].
  - With no simultaneous accept: go to EMPTY.
  - With a simultaneous accept: stay FULL with the new beat.
- Packet lock:
  - First accepted beat with i_last=0 sets lock and latches ch_q.
  - Later beats ignore s.
  - An accepted beat with i_last=1 clears lock after that beat.
  - A single-beat packet (i_last=1 on the first beat) never sets lock.
- busy = lock.
- Out-of-range select (s >= M, only possible when M is not a power of 2), evaluated on a first beat:
  - Beat is accepted and discarded; the stage stays in its current state.
  - err pulses for 1 cycle.
  - If that beat has i_last=0, lock is set to a drop mode: the remaining beats of the packet are accepted and discarded (i_ready=1), err pulses once per beat, and lock clears on i_last.
- Stall: a FULL stage with y_ready[ch_q]=0 holds data_q, ch_q and y_valid stable. Unselected y_ready bits are ignored.
- Unselected channel data slices drive 0 (see Optional Feature).
- rst mid-packet: the held beat is lost and lock is cleared. The next beat is treated as a first beat.

Optional Feature:
- Macro DEMUX_TRISTATE_EN.
  - Defined: unselected y_data slices, and all slices while EMPTY, drive 'z. This matches the tristate style of the earlier demux for shared-bus use.
  - Undefined: those slices drive 0.
- y_valid behaviour is identical in both builds.

Decomposition:
- Package demux_pkg:
  - state enum {EMPTY, FULL}.
  - lock-mode enum {UNLOCKED, LOCKED, DROP}.
  - function onehot(sel, M) returning the y_valid mask.
- Sub-module demux_hold_reg: one-deep W+1-bit register (data + last) with load/clear.
- The top level holds the lock FSM, channel latch and output fan-out.

Test Plan (W=8, M=4 unless stated):
- Single-beat routing: s=2, i_data=0xA5, i_last=1, all y_ready=1 -> next cycle y_valid=4'b0100, y_data[23:16]=0xA5, y_data other slices=0, busy=0.
- Packet lock: 3 beats 0x11/0x22/0x33, s changes 1->3->0 during the packet, last on beat 3 -> all beats appear on channel 1; busy high from cycle after beat 1 until after beat 3.
- Backpressure: channel 0 with y_ready[0]=0 for 4 cycles while i_valid=1 -> i_ready=0, held beat stable; y_ready[3]=1 has no effect; on release, back-to-back beats at 1/cycle.
- Out-of-range select (M=3): s=3, 2-beat packet -> both beats accepted, no y_valid, err pulses twice; next packet with s=1 routes normally.
- Async reset mid-packet: rst pulses between beats 2 and 3 -> y_valid=0 immediately, busy=0; the following beat with s=0 routes to channel 0.
- DEMUX_TRISTATE_EN build: s=1 held beat -> slices 0, 2, 3 read 'z; all slices read 'z when EMPTY.
